// File: rtl/elevator_call_scheduler.sv
// Three-floor elevator sequencer: latches floor calls, picks travel direction
// with a SCAN policy, and times motor travel and door dwell in clock cycles.
module elevator_call_scheduler #(
  parameter int TRAVEL_TIME = 2,
  parameter int DOOR_TIME   = 3,
  parameter int TW          = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] call,
  input  logic       full,
  output logic [1:0] floor,
  output logic [2:0] pending,
  output logic       move_up,
  output logic       move_down,
  output logic       door_open,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TIME - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_TIME - 1);

  state_t        state, state_nxt;
  logic [1:0]    floor_nxt;
  logic [2:0]    pending_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          dir, dir_nxt;

  logic [2:0]    accepted;
  logic [2:0]    req;
  logic [2:0]    here_mask;
  logic [1:0]    arr_floor;
  logic [2:0]    arr_mask;
  logic          arr_limit;

  function automatic logic [2:0] floor_mask(input logic [1:0] f);
    case (f)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic calls_above(input logic [2:0] r, input logic [1:0] f);
    case (f)
      2'd0:    return |r[2:1];
      2'd1:    return r[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic calls_below(input logic [2:0] r, input logic [1:0] f);
    case (f)
      2'd1:    return r[0];
      2'd2:    return |r[1:0];
      default: return 1'b0;
    endcase
  endfunction

  assign accepted  = call & {3{~full}};
  assign req       = pending | accepted;
  assign here_mask = floor_mask(floor);

  always_comb begin
    state_nxt   = state;
    floor_nxt   = floor;
    pending_nxt = req;
    timer_nxt   = timer;
    dir_nxt     = dir;
    arr_floor   = floor;
    arr_mask    = 3'b000;
    arr_limit   = 1'b0;

    case (state)
      IDLE: begin
        // A call at the car's floor opens the door at once; travel decisions
        // only look at already-latched calls, so they react one edge later.
        if (|(req & here_mask)) begin
          state_nxt   = DOOR;
          timer_nxt   = '0;
          pending_nxt = req & ~here_mask;
        end else if (calls_above(pending, floor)) begin
          state_nxt = MOVE_UP;
          dir_nxt   = 1'b1;
          timer_nxt = '0;
        end else if (calls_below(pending, floor)) begin
          state_nxt = MOVE_DOWN;
          dir_nxt   = 1'b0;
          timer_nxt = '0;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (timer == TRAVEL_LAST) begin
          if (state == MOVE_UP) begin
            arr_floor = (floor == 2'd2) ? 2'd2 : floor + 2'd1;
            arr_limit = (arr_floor == 2'd2);
          end else begin
            arr_floor = (floor == 2'd0) ? 2'd0 : floor - 2'd1;
            arr_limit = (arr_floor == 2'd0);
          end
          arr_mask  = floor_mask(arr_floor);
          floor_nxt = arr_floor;
          timer_nxt = '0;
          // Reaching the end of the shaft always stops the car there.
          if (|(req & arr_mask) || arr_limit) begin
            state_nxt   = DOOR;
            pending_nxt = req & ~arr_mask;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      DOOR: begin
        pending_nxt = req & ~here_mask;
        if (|(accepted & here_mask)) begin
          timer_nxt = '0;
        end else if (timer == DOOR_LAST) begin
          timer_nxt = '0;
          if (dir ? calls_above(req, floor) : calls_below(req, floor)) begin
            state_nxt = dir ? MOVE_UP : MOVE_DOWN;
          end else if (dir ? calls_below(req, floor) : calls_above(req, floor)) begin
            dir_nxt   = ~dir;
            state_nxt = dir ? MOVE_DOWN : MOVE_UP;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      floor   <= 2'd0;
      pending <= 3'b000;
      timer   <= '0;
      dir     <= 1'b1;
    end else begin
      state   <= state_nxt;
      floor   <= floor_nxt;
      pending <= pending_nxt;
      timer   <= timer_nxt;
      dir     <= dir_nxt;
    end
  end

  assign move_up   = (state == MOVE_UP);
  assign move_down = (state == MOVE_DOWN);
  assign door_open = (state == DOOR);
  assign busy      = (state != IDLE);

  // Motor and door must never be commanded together; floor code 11 is unused.
  assert property (@(posedge clk) disable iff (reset) $onehot0({move_up, move_down, door_open}));
  assert property (@(posedge clk) disable iff (reset) floor != 2'd3);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench for elevator_call_scheduler: a cycle-level behavioural model
// predicts the outputs after every edge; a negedge monitor compares them.
module tb_elevator_call_scheduler;

  localparam int TRAVEL_TIME = 2;
  localparam int DOOR_TIME   = 3;
  localparam int TW          = 3;

  localparam int PH_IDLE = 0;
  localparam int PH_UP   = 1;
  localparam int PH_DOWN = 2;
  localparam int PH_DOOR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] call = 3'b000;
  logic       full = 1'b0;
  logic [1:0] floor;
  logic [2:0] pending;
  logic       move_up, move_down, door_open, busy;

  int tests_run = 0;
  int failures  = 0;
  int cycle_no  = 0;

  logic [8:0] exp_q[$];

  int     m_phase = PH_IDLE;
  int     m_floor = 0;
  int     m_left  = 0;
  bit [2:0] m_pend = 3'b000;
  bit     m_up = 1'b1;

  elevator_call_scheduler #(
    .TRAVEL_TIME(TRAVEL_TIME),
    .DOOR_TIME  (DOOR_TIME),
    .TW         (TW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .call     (call),
    .full     (full),
    .floor    (floor),
    .pending  (pending),
    .move_up  (move_up),
    .move_down(move_down),
    .door_open(door_open),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic bit any_call(input bit [2:0] r, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (i >= 0 && i <= 2 && r[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Model: m_left counts the cycles remaining in the current travel leg or dwell.
  task automatic modelStep(input bit r, input bit [2:0] c, input bit f);
    bit [2:0] req;
    int nf;
    bit ahead, behind;
    if (r) begin
      m_phase = PH_IDLE; m_floor = 0; m_pend = 3'b000; m_left = 0; m_up = 1'b1;
      return;
    end
    req = m_pend | (f ? 3'b000 : c);
    case (m_phase)
      PH_IDLE: begin
        if (req[m_floor]) begin
          m_phase = PH_DOOR; m_left = DOOR_TIME; req[m_floor] = 1'b0;
        end else if (any_call(m_pend, m_floor + 1, 2)) begin
          m_phase = PH_UP; m_up = 1'b1; m_left = TRAVEL_TIME;
        end else if (any_call(m_pend, 0, m_floor - 1)) begin
          m_phase = PH_DOWN; m_up = 1'b0; m_left = TRAVEL_TIME;
        end
      end
      PH_UP, PH_DOWN: begin
        if (m_left > 1) begin
          m_left--;
        end else begin
          nf = m_floor + ((m_phase == PH_UP) ? 1 : -1);
          if (nf > 2) nf = 2;
          if (nf < 0) nf = 0;
          m_floor = nf;
          m_left  = TRAVEL_TIME;
          if (req[nf] || (m_phase == PH_UP && nf == 2) || (m_phase == PH_DOWN && nf == 0)) begin
            m_phase = PH_DOOR; m_left = DOOR_TIME; req[nf] = 1'b0;
          end
        end
      end
      PH_DOOR: begin
        if (!f && c[m_floor]) begin
          m_left = DOOR_TIME;
        end else if (m_left > 1) begin
          m_left--;
        end else begin
          ahead  = m_up ? any_call(req, m_floor + 1, 2) : any_call(req, 0, m_floor - 1);
          behind = m_up ? any_call(req, 0, m_floor - 1) : any_call(req, m_floor + 1, 2);
          if (ahead) begin
            m_phase = m_up ? PH_UP : PH_DOWN; m_left = TRAVEL_TIME;
          end else if (behind) begin
            m_up = !m_up; m_phase = m_up ? PH_UP : PH_DOWN; m_left = TRAVEL_TIME;
          end else begin
            m_phase = PH_IDLE;
          end
        end
        req[m_floor] = 1'b0;
      end
      default: ;
    endcase
    m_pend = req;
  endtask

  function automatic logic [8:0] model_outputs();
    return {2'(m_floor), m_pend, m_phase == PH_UP, m_phase == PH_DOWN,
            m_phase == PH_DOOR, m_phase != PH_IDLE};
  endfunction

  task automatic applyStimulus(input bit r, input bit [2:0] c, input bit f);
    reset = r;
    call  = c;
    full  = f;
    modelStep(r, c, f);
    exp_q.push_back(model_outputs());
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input logic [8:0] exp);
    logic [8:0] act;
    act = {floor, pending, move_up, move_down, door_open, busy};
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL cycle %0d outputs: got floor=%b pending=%b up=%b down=%b door=%b busy=%b, expected floor=%b pending=%b up=%b down=%b door=%b busy=%b",
               cycle_no, act[8:7], act[6:4], act[3], act[2], act[1], act[0],
               exp[8:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  always @(negedge clk) begin
    cycle_no++;
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    int guard;
    int qleft;
    bit [2:0] rc;

    // Reset, then a quiet idle period.
    applyStimulus(1'b1, 3'b000, 1'b0);
    applyStimulus(1'b1, 3'b000, 1'b0);
    repeat (10) applyStimulus(1'b0, 3'b000, 1'b0);

    // One-cycle call to the top floor.
    applyStimulus(1'b0, 3'b100, 1'b0);
    repeat (12) applyStimulus(1'b0, 3'b000, 1'b0);

    // From the top with dir up: two calls below, served on the way down.
    applyStimulus(1'b0, 3'b011, 1'b0);
    repeat (20) applyStimulus(1'b0, 3'b000, 1'b0);

    // Car full: calls ignored, but an earlier call is still served.
    repeat (3) applyStimulus(1'b0, 3'b111, 1'b1);
    repeat (3) applyStimulus(1'b0, 3'b000, 1'b1);
    applyStimulus(1'b0, 3'b100, 1'b0);
    repeat (12) applyStimulus(1'b0, 3'b001, 1'b1);
    repeat (3) applyStimulus(1'b0, 3'b000, 1'b0);

    // Door at floor 1 held open by a repeated call there.
    applyStimulus(1'b0, 3'b010, 1'b0);
    guard = 0;
    while (!(m_phase == PH_DOOR && m_floor == 1) && guard < 30) begin
      applyStimulus(1'b0, 3'b000, 1'b0);
      guard++;
    end
    if (guard >= 30) begin
      tests_run++;
      failures++;
      $display("[TB] FAIL door-at-floor-1 setup: got no door after %0d cycles, expected door within 30", guard);
    end
    repeat (2) applyStimulus(1'b0, 3'b010, 1'b0);
    repeat (8) applyStimulus(1'b0, 3'b000, 1'b0);

    // Reset in the middle of a trip from floor 0 to floor 1.
    applyStimulus(1'b1, 3'b000, 1'b0);
    applyStimulus(1'b0, 3'b010, 1'b0);
    applyStimulus(1'b0, 3'b000, 1'b0);
    applyStimulus(1'b0, 3'b000, 1'b0);
    applyStimulus(1'b1, 3'b111, 1'b0);
    repeat (3) applyStimulus(1'b0, 3'b000, 1'b0);

    // Random traffic with occasional full and rare resets.
    for (int n = 0; n < 600; n++) begin
      rc = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      applyStimulus($urandom_range(0, 199) == 0, rc, $urandom_range(0, 4) == 0);
    end
    repeat (20) applyStimulus(1'b0, 3'b000, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    qleft = exp_q.size();
    tests_run++;
    if (qleft != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard drain: got %0d unchecked entries, expected 0", qleft);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Sequences the three-floor elevator car: latches floor calls from switches A0–A2, chooses the travel direction with a SCAN (keep-direction-while-calls-ahead) policy, and times motor travel and door dwell. The block owns the car position counter. It drives the 2-bit floor code consumed by the floor display/decoder logic. Runs on the 1 Hz clock from the clock divider, so all timers count clock cycles.

## Interface
- TRAVEL_TIME, default 2: cycles to move one floor (≥1).
- DOOR_TIME, default 3: cycles the door stays open per stop (≥1).
- TW, default 3: width of the shared travel/door timer; must hold max(TRAVEL_TIME, DOOR_TIME)−1.

Ports:
- clk  in  1  system clock (1 Hz tick from divider); single clock domain.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- call  in  3  floor call requests, bit i = floor i; level, sampled each edge.
- full  in  1  car full (C); while 1, new calls are not accepted.
- floor  out  2  current car floor: 00, 01, 10; 11 never driven.
- pending  out  3  latched, not-yet-served calls.
- move_up  out  1  motor up, high for the whole MOVE_UP state.
- move_down  out  1  motor down, high for the whole MOVE_DOWN state.
- door_open  out  1  high for the whole DOOR state.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR. Internal dir register: 1 = up, 0 = down. Reset value of dir: up.
- Reset values: state IDLE, floor 00, pending 000, timer 0, dir up. All outputs are 0 except floor = 00.
- Call acceptance: accepted = call & {3{~full}}. Each edge, pending |= accepted. The bit for the floor being served this edge is excluded.
  - Served in IDLE: pending at the current floor.
  - Served in DOOR: a call at the current floor.
  - Served on arrival: pending at the arrival floor.
- here, above, below are computed from pending | accepted against floor.
  - above = any call at a higher floor; below = any call at a lower floor.
- IDLE:
  - here → DOOR. Clear that bit, timer = 0.
  - else above → MOVE_UP, dir = up.
  - else below → MOVE_DOWN, dir = down.
  - Priority: here > above > below.
- MOVE_UP / MOVE_DOWN:
  - The timer increments each edge.
  - At timer == TRAVEL_TIME−1, floor moves ±1 and the timer clears.
  - If the new floor has a call → DOOR and clear its bit. Otherwise keep the same direction.
  - floor saturates at 10 going up and 00 going down. Reaching a limit with no call there is illegal: force DOOR at the limit.
- DOOR:
  - The timer increments each edge.
  - An accepted call at the current floor restarts the timer to 0 and is not latched.
  - At timer == DOOR_TIME−1, exit as follows:
    - calls ahead in dir → move in dir;
    - else calls behind → reverse (update dir) and move;
    - else → IDLE.
- full only gates acceptance. Calls already pending are still served. The door is not held by full.

## Timing
- Call sampled at edge E0 → pending visible after E0. The state reacts at E1.
- In IDLE, a here-call at E0 is handled immediately: door_open rises after E0, and pending never shows the bit.
- One-floor trip: MOVE entered at E1; floor changes at E1+TRAVEL_TIME.
- Door dwell: door_open high for exactly DOOR_TIME cycles unless restarted.
- Motor and door outputs are registered state decodes. move_up, move_down and door_open are mutually exclusive, and never high in the same cycle.
- Reset mid-travel or mid-door: next edge returns everything to reset values (floor 00), regardless of the other inputs.

## Test plan
- Reset, then IDLE with no calls → all outputs 0, floor 00, busy 0, stable for 10 cycles.
- At floor 0, pulse call=100 one cycle (defaults):
  - pending=100 next cycle;
  - move_up for 4 cycles; floor 01 after 2, 10 after 4;
  - then door_open 3 cycles, pending 000, back to IDLE.
- At floor 2 with dir up, calls 001 and 010 latched → doors at floor 1 then floor 0, with move_down throughout and no reversal.
- full=1 while call=111 pulses → pending stays 000 and the car stays IDLE.
  - full=1 with pending=100 already set → the car still travels to floor 2.
- Door open at floor 1, call=010 held 2 extra cycles → door_open lasts 2+3 cycles total, pending bit 1 never set.
- reset asserted during MOVE_UP between floors 0 and 1 → next cycle floor 00, pending 000, move_up 0, IDLE.
